// File: rtl/sata_prims_pkg.sv
// Shared SATA primitive definitions: dword constants, prim_vec bit indices,
// receive-decoder state encoding and decode result struct.
package sata_prims_pkg;

    localparam int unsigned NUM_LINK_PRIMS = 16;
    localparam int unsigned DWORD_WIDTH    = 32;

    localparam logic [31:0] PRIM_ALIGN   = 32'h7B4A_4ABC;
    localparam logic [31:0] PRIM_CONT    = 32'h9999_AA7C;
    localparam logic [31:0] PRIM_SYNC    = 32'hB5B5_957C;
    localparam logic [31:0] PRIM_R_RDY   = 32'h4A4A_957C;
    localparam logic [31:0] PRIM_R_IP    = 32'h5555_B57C;
    localparam logic [31:0] PRIM_R_OK    = 32'h3535_B57C;
    localparam logic [31:0] PRIM_R_ERR   = 32'h5656_B57C;
    localparam logic [31:0] PRIM_SOF     = 32'h3737_B57C;
    localparam logic [31:0] PRIM_EOF     = 32'hD5D5_B57C;
    localparam logic [31:0] PRIM_X_RDY   = 32'h5757_B57C;
    localparam logic [31:0] PRIM_WTRM    = 32'h5858_B57C;
    localparam logic [31:0] PRIM_HOLD    = 32'hD5D5_AA7C;
    localparam logic [31:0] PRIM_HOLDA   = 32'h9595_AA7C;
    localparam logic [31:0] PRIM_DMAT    = 32'h3636_B57C;
    localparam logic [31:0] PRIM_PMREQ_P = 32'h1717_B57C;
    localparam logic [31:0] PRIM_PMREQ_S = 32'h7575_957C;
    localparam logic [31:0] PRIM_PMACK   = 32'h9595_957C;
    localparam logic [31:0] PRIM_PMNAK   = 32'hF5F5_957C;

    localparam int unsigned IDX_SYNC    = 0;
    localparam int unsigned IDX_R_RDY   = 1;
    localparam int unsigned IDX_R_IP    = 2;
    localparam int unsigned IDX_R_OK    = 3;
    localparam int unsigned IDX_R_ERR   = 4;
    localparam int unsigned IDX_SOF     = 5;
    localparam int unsigned IDX_EOF     = 6;
    localparam int unsigned IDX_X_RDY   = 7;
    localparam int unsigned IDX_WTRM    = 8;
    localparam int unsigned IDX_HOLD    = 9;
    localparam int unsigned IDX_HOLDA   = 10;
    localparam int unsigned IDX_DMAT    = 11;
    localparam int unsigned IDX_PMREQ_P = 12;
    localparam int unsigned IDX_PMREQ_S = 13;
    localparam int unsigned IDX_PMACK   = 14;
    localparam int unsigned IDX_PMNAK   = 15;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_PRIM = 2'd1,
        ST_CONT = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic                      is_align;
        logic                      is_cont;
        logic                      is_data;
        logic                      is_unknown;
        logic [NUM_LINK_PRIMS-1:0] onehot;
    } prim_dec_t;

endpackage

// File: rtl/sata_prim_decode.sv
// Combinational classifier: one PHY dword + charisk -> ALIGN/CONT/data/unknown
// flags and a one-hot link primitive.
module sata_prim_decode
    import sata_prims_pkg::*;
(
    input  logic [31:0] rx_data,
    input  logic [3:0]  rx_charisk,
    output prim_dec_t   dec_c
);

    always_comb begin
        dec_c = '0;
        if (rx_charisk == 4'b0000) begin
            dec_c.is_data = 1'b1;
        end else if (rx_charisk == 4'b0001) begin
            case (rx_data)
                PRIM_ALIGN:   dec_c.is_align              = 1'b1;
                PRIM_CONT:    dec_c.is_cont               = 1'b1;
                PRIM_SYNC:    dec_c.onehot[IDX_SYNC]      = 1'b1;
                PRIM_R_RDY:   dec_c.onehot[IDX_R_RDY]     = 1'b1;
                PRIM_R_IP:    dec_c.onehot[IDX_R_IP]      = 1'b1;
                PRIM_R_OK:    dec_c.onehot[IDX_R_OK]      = 1'b1;
                PRIM_R_ERR:   dec_c.onehot[IDX_R_ERR]     = 1'b1;
                PRIM_SOF:     dec_c.onehot[IDX_SOF]       = 1'b1;
                PRIM_EOF:     dec_c.onehot[IDX_EOF]       = 1'b1;
                PRIM_X_RDY:   dec_c.onehot[IDX_X_RDY]     = 1'b1;
                PRIM_WTRM:    dec_c.onehot[IDX_WTRM]      = 1'b1;
                PRIM_HOLD:    dec_c.onehot[IDX_HOLD]      = 1'b1;
                PRIM_HOLDA:   dec_c.onehot[IDX_HOLDA]     = 1'b1;
                PRIM_DMAT:    dec_c.onehot[IDX_DMAT]      = 1'b1;
                PRIM_PMREQ_P: dec_c.onehot[IDX_PMREQ_P]   = 1'b1;
                PRIM_PMREQ_S: dec_c.onehot[IDX_PMREQ_S]   = 1'b1;
                PRIM_PMACK:   dec_c.onehot[IDX_PMACK]     = 1'b1;
                PRIM_PMNAK:   dec_c.onehot[IDX_PMNAK]     = 1'b1;
                default:      dec_c.is_unknown            = 1'b1;
            endcase
        end else begin
            dec_c.is_unknown = 1'b1;
        end
    end

endmodule

// File: rtl/sata_prim_rx.sv
// SATA receive primitive decoder: registered one-hot primitive / data strobe
// with CONT expansion. Optional errored-dword counter: SATA_PRIM_RX_ERRCNT_EN.
module sata_prim_rx
    import sata_prims_pkg::*;
#(
    parameter int unsigned DATA_BYTE_WIDTH = 4,
    parameter int unsigned ERR_CNT_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         phy_ready,
    input  logic [DATA_BYTE_WIDTH*8-1:0] rx_data,
    input  logic [DATA_BYTE_WIDTH-1:0]   rx_charisk,
    input  logic [DATA_BYTE_WIDTH-1:0]   rx_err,
    output logic [NUM_LINK_PRIMS-1:0]    prim_vec,
    output logic                         data_valid,
    output logic [DATA_BYTE_WIDTH*8-1:0] data_out,
    output logic                         dword_err,
    output logic                         align_det,
    output logic                         unknown_prim,
    output logic                         cont_active,
    output logic [ERR_CNT_WIDTH-1:0]     err_cnt
);

    if (DATA_BYTE_WIDTH != 4) begin : g_width_check
        $error("sata_prim_rx: only DATA_BYTE_WIDTH=4 is supported");
    end

    prim_dec_t                 dec_c;
    rx_state_e                 state;
    logic [NUM_LINK_PRIMS-1:0] last_prim;

    sata_prim_decode u_decode (
        .rx_data    (rx_data),
        .rx_charisk (rx_charisk),
        .dec_c      (dec_c)
    );

    // Classification FSM; last_prim is zero exactly when state is ST_NONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_NONE;
            last_prim    <= '0;
            prim_vec     <= '0;
            data_valid   <= 1'b0;
            data_out     <= '0;
            dword_err    <= 1'b0;
            align_det    <= 1'b0;
            unknown_prim <= 1'b0;
            cont_active  <= 1'b0;
        end else begin
            prim_vec     <= '0;
            data_valid   <= 1'b0;
            data_out     <= '0;
            dword_err    <= 1'b0;
            align_det    <= 1'b0;
            unknown_prim <= 1'b0;
            cont_active  <= 1'b0;
            if (!phy_ready) begin
                state     <= ST_NONE;
                last_prim <= '0;
            end else begin
                dword_err   <= |rx_err;
                cont_active <= (state == ST_CONT);
                if (dec_c.is_align) begin
                    align_det <= 1'b1;
                end else if (|dec_c.onehot) begin
                    prim_vec    <= dec_c.onehot;
                    last_prim   <= dec_c.onehot;
                    state       <= ST_PRIM;
                    cont_active <= 1'b0;
                end else begin
                    case (state)
                        ST_CONT: begin
                            // Scrambled junk between CONT and the next primitive.
                            prim_vec <= last_prim;
                        end
                        ST_PRIM: begin
                            if (dec_c.is_cont) begin
                                prim_vec    <= last_prim;
                                state       <= ST_CONT;
                                cont_active <= 1'b1;
                            end else if (dec_c.is_data) begin
                                data_valid <= 1'b1;
                                data_out   <= rx_data;
                                state      <= ST_NONE;
                                last_prim  <= '0;
                            end else begin
                                unknown_prim <= 1'b1;
                            end
                        end
                        default: begin
                            // CONT with no preceding primitive is dropped silently.
                            if (dec_c.is_data) begin
                                data_valid <= 1'b1;
                                data_out   <= rx_data;
                            end else if (dec_c.is_unknown) begin
                                unknown_prim <= 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

`ifdef SATA_PRIM_RX_ERRCNT_EN
    // Saturating count of errored dwords seen while the link is up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (phy_ready && (|rx_err) && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_sata_prim_rx.sv
// Directed self-checking bench for sata_prim_rx; err_cnt expectations follow
// SATA_PRIM_RX_ERRCNT_EN.
module tb_sata_prim_rx;

    localparam int unsigned CW = 16;

    logic        clk;
    logic        rst_n;
    logic        phy_ready;
    logic [31:0] rx_data;
    logic [3:0]  rx_charisk;
    logic [3:0]  rx_err;
    logic [15:0] prim_vec;
    logic        data_valid;
    logic [31:0] data_out;
    logic        dword_err;
    logic        align_det;
    logic        unknown_prim;
    logic        cont_active;
    logic [CW-1:0] err_cnt;

    int unsigned vectors;
    int unsigned miscompares;
    logic [CW-1:0] err_model;

    sata_prim_rx #(
        .DATA_BYTE_WIDTH (4),
        .ERR_CNT_WIDTH   (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .phy_ready    (phy_ready),
        .rx_data      (rx_data),
        .rx_charisk   (rx_charisk),
        .rx_err       (rx_err),
        .prim_vec     (prim_vec),
        .data_valid   (data_valid),
        .data_out     (data_out),
        .dword_err    (dword_err),
        .align_det    (align_det),
        .unknown_prim (unknown_prim),
        .cont_active  (cont_active),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one dword on the falling edge; outputs are valid #1 after the next rising edge.
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic [3:0] e);
        @(negedge clk);
        rx_data    = d;
        rx_charisk = k;
        rx_err     = e;
`ifdef SATA_PRIM_RX_ERRCNT_EN
        if (phy_ready && (|e) && (err_model != '1)) err_model = err_model + CW'(1);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [15:0] pv, input logic dv,
                           input logic [31:0] dout, input logic al, input logic un,
                           input logic ca, input logic de);
        chk({tag, ".prim_vec"},     32'(prim_vec),     32'(pv));
        chk({tag, ".data_valid"},   32'(data_valid),   32'(dv));
        chk({tag, ".data_out"},     data_out,          dout);
        chk({tag, ".align_det"},    32'(align_det),    32'(al));
        chk({tag, ".unknown_prim"}, 32'(unknown_prim), 32'(un));
        chk({tag, ".cont_active"},  32'(cont_active),  32'(ca));
        chk({tag, ".dword_err"},    32'(dword_err),    32'(de));
        chk({tag, ".err_cnt"},      32'(err_cnt),      32'(err_model));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        err_model   = '0;
        rst_n       = 1'b0;
        phy_ready   = 1'b0;
        rx_data     = '0;
        rx_charisk  = '0;
        rx_err      = '0;

        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n     = 1'b1;
        phy_ready = 1'b1;

        // X_RDY repeated then CONT-compressed with junk
        send(32'h5757_B57C, 4'b0001, 4'b0000); chk_all("xrdy0", 16'h0080, 0, 0, 0, 0, 0, 0);
        send(32'h5757_B57C, 4'b0001, 4'b0000); chk_all("xrdy1", 16'h0080, 0, 0, 0, 0, 0, 0);
        send(32'h9999_AA7C, 4'b0001, 4'b0000); chk_all("xrdy_cont", 16'h0080, 0, 0, 0, 0, 1, 0);
        send(32'h1234_5678, 4'b0000, 4'b0000); chk_all("xrdy_junk0", 16'h0080, 0, 0, 0, 0, 1, 0);
        send(32'hDEAD_BEEF, 4'b0000, 4'b0000); chk_all("xrdy_junk1", 16'h0080, 0, 0, 0, 0, 1, 0);

        // HOLD stream with ALIGN inserted inside CONT
        send(32'hD5D5_AA7C, 4'b0001, 4'b0000); chk_all("hold", 16'h0200, 0, 0, 0, 0, 0, 0);
        send(32'h9999_AA7C, 4'b0001, 4'b0000); chk_all("hold_cont", 16'h0200, 0, 0, 0, 0, 1, 0);
        send(32'h7B4A_4ABC, 4'b0001, 4'b0000); chk_all("hold_align", 16'h0000, 0, 0, 1, 0, 1, 0);
        send(32'hCAFE_F00D, 4'b0000, 4'b0000); chk_all("hold_junk", 16'h0200, 0, 0, 0, 0, 1, 0);
        send(32'h0000_007C, 4'b0001, 4'b0000); chk_all("hold_unk_junk", 16'h0200, 0, 0, 0, 0, 1, 0);

        // SOF, payload, then a CONT that must be ignored
        send(32'h3737_B57C, 4'b0001, 4'b0000); chk_all("sof", 16'h0020, 0, 0, 0, 0, 0, 0);
        send(32'hA5A5_A5A5, 4'b0000, 4'b0000); chk_all("payload", 16'h0000, 1, 32'hA5A5_A5A5, 0, 0, 0, 0);
        send(32'h9999_AA7C, 4'b0001, 4'b0000); chk_all("cont_ignored", 16'h0000, 0, 0, 0, 0, 0, 0);

        // Unknown K-dwords and errored dwords outside CONT
        send(32'h0000_007C, 4'b0001, 4'b0000); chk_all("unknown", 16'h0000, 0, 0, 0, 1, 0, 0);
        send(32'h0000_007C, 4'b0001, 4'b0001); chk_all("unknown_err", 16'h0000, 0, 0, 0, 1, 0, 1);
        send(32'h3535_B57C, 4'b0001, 4'b0100); chk_all("rok_err", 16'h0008, 0, 0, 0, 0, 0, 1);
        send(32'h0000_00BC, 4'b0011, 4'b0000); chk_all("unknown_k2", 16'h0000, 0, 0, 0, 1, 0, 0);
        send(32'hF5F5_957C, 4'b0001, 4'b0000); chk_all("pmnak", 16'h8000, 0, 0, 0, 0, 0, 0);

        // Counter saturation: 2^16+3 errored payload dwords
        for (int i = 0; i < 65539; i++) send(32'h0000_0001, 4'b0000, 4'b0010);
        chk_all("sat", 16'h0000, 1, 32'h1, 0, 0, 0, 1);
`ifdef SATA_PRIM_RX_ERRCNT_EN
        chk("sat_value", 32'(err_cnt), 32'h0000_FFFF);
`else
        chk("sat_value", 32'(err_cnt), 32'h0000_0000);
`endif

        // Drop phy_ready mid-CONT; following CONT ignored until a new primitive
        send(32'h5555_B57C, 4'b0001, 4'b0000); chk_all("rip", 16'h0004, 0, 0, 0, 0, 0, 0);
        send(32'h9999_AA7C, 4'b0001, 4'b0000); chk_all("rip_cont", 16'h0004, 0, 0, 0, 0, 1, 0);
        phy_ready = 1'b0;
        send(32'h1111_2222, 4'b0000, 4'b0001); chk_all("phy_down", 16'h0000, 0, 0, 0, 0, 0, 0);
        phy_ready = 1'b1;
        send(32'h9999_AA7C, 4'b0001, 4'b0000); chk_all("cont_after_down", 16'h0000, 0, 0, 0, 0, 0, 0);
        send(32'h5858_B57C, 4'b0001, 4'b0000); chk_all("wtrm", 16'h0100, 0, 0, 0, 0, 0, 0);
        send(32'h9999_AA7C, 4'b0001, 4'b0000); chk_all("wtrm_cont", 16'h0100, 0, 0, 0, 0, 1, 0);

        // Asynchronous reset mid-stream clears outputs immediately
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        err_model = '0;
        chk_all("async_rst", 16'h0000, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(32'h9999_AA7C, 4'b0001, 4'b0000); chk_all("cont_after_rst", 16'h0000, 0, 0, 0, 0, 0, 0);
        send(32'h9595_AA7C, 4'b0001, 4'b0000); chk_all("holda", 16'h0400, 0, 0, 0, 0, 0, 0);
        send(32'h9999_AA7C, 4'b0001, 4'b0000); chk_all("holda_cont", 16'h0400, 0, 0, 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sata_prim_rx.md
# sata_prim_rx

Receive-side primitive decoder sitting directly downstream of the SATA PHY, consuming its 32-bit dword stream (data, charisk, per-byte error) in the `clk` (usrclk2) domain and feeding the link-layer state machine. Classifies each dword as a link primitive, ALIGN, CONT, payload data or garbage, expands CONT-compressed primitive streams, and suppresses scrambled CONT junk. Output is one registered, one-hot primitive vector plus a data strobe, so the link FSM never parses raw K-codes.

## Interface
- `DATA_BYTE_WIDTH`, 4, PHY dword width in bytes; only 4 supported (elaboration error otherwise).
- `ERR_CNT_WIDTH`, 16, width of the saturating code-error counter.

- `clk`  in  1  sata clock (usrclk2 from PHY); all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `phy_ready`  in  1  PHY link established; low = stream invalid.
- `rx_data`  in  32  received dword (byte 0 = bits 7:0).
- `rx_charisk`  in  4  per-byte K flag.
- `rx_err`  in  4  per-byte disparity/not-in-table error.
- `prim_vec`  out  16  one-hot primitive this cycle: [0]SYNC [1]R_RDY [2]R_IP [3]R_OK [4]R_ERR [5]SOF [6]EOF [7]X_RDY [8]WTRM [9]HOLD [10]HOLDA [11]DMAT [12]PMREQ_P [13]PMREQ_S [14]PMACK [15]PMNAK.
- `data_valid`  out  1  `data_out` carries a payload dword.
- `data_out`  out  32  payload dword (raw, still scrambled).
- `dword_err`  out  1  source dword had any `rx_err` bit set.
- `align_det`  out  1  ALIGN received.
- `unknown_prim`  out  1  charisk != 0 and not a recognised primitive/ALIGN/CONT.
- `cont_active`  out  1  currently expanding a CONT sequence.
- `err_cnt`  out  ERR_CNT_WIDTH  saturating count of errored dwords (only with macro).

## Operation
- Recognition: primitive iff `rx_charisk == 4'b0001` and `rx_data` matches a constant from the package (ALIGN 0x7B4A4ABC, CONT 0x9999AA7C, SYNC 0xB5B5957C, R_RDY 0x4A4A957C, R_IP 0x5555B57C, R_OK 0x3535B57C, R_ERR 0x5656B57C, SOF 0x3737B57C, EOF 0xD5D5B57C, X_RDY 0x5757B57C, WTRM 0x5858B57C, HOLD 0xD5D5AA7C, HOLDA 0x9595AA7C, DMAT 0x3636B57C, PMREQ_P 0x1717B57C, PMREQ_S 0x7575957C, PMACK 0x9595957C, PMNAK 0xF5F5957C). Any other nonzero charisk -> unknown.
- State: `last_prim` (16-bit one-hot, 0 = none), `cont` flag. FSM states NONE (last_prim==0), PRIM (!cont), CONT (cont).
- Link primitive P: `prim_vec`=P, `last_prim`<=P, `cont`<=0 -> PRIM.
- CONT in PRIM: `cont`<=1 -> CONT; `prim_vec`=last_prim. CONT in NONE: ignored, all strobes 0, stay NONE. CONT in CONT: `prim_vec`=last_prim.
- In CONT, data dwords (charisk 0) and unknown dwords are junk: `prim_vec`=last_prim, `data_valid`=0, `unknown_prim`=0.
- ALIGN (any state): `align_det`=1, `prim_vec`=0, `data_valid`=0; `last_prim`, `cont` unchanged.
- Data dword outside CONT: `data_valid`=1, `data_out`=rx_data, `prim_vec`=0; state -> NONE (last_prim cleared, so a later CONT without a fresh primitive is ignored).
- Unknown outside CONT: `unknown_prim`=1, other strobes 0, state unchanged.
- `dword_err` = |rx_err for every dword, independent of classification; an errored dword is still classified by content.
- `phy_ready`=0: all outputs 0 next cycle, state -> NONE; `err_cnt` held.

## Timing
- Latency: exactly 1 clk, input dword to registered outputs; no back-pressure, one dword per cycle.
- Reset (`rst_n` low, async): all outputs 0, state NONE, `err_cnt`=0. Release mid-stream: first valid output is the cycle after the first sampled dword.
- `err_cnt` increments on cycles with `phy_ready` & |rx_err; saturates at all-ones, never wraps.

## Configuration
- `SATA_PRIM_RX_ERRCNT_EN` defined: `err_cnt` counter implemented as above.
- Undefined: counter removed, `err_cnt` tied to 0; all other behaviour identical.

## Structure
- Shared package `sata_prims_pkg`: 18 primitive dword constants, prim_vec bit-index localparams, NUM_LINK_PRIMS=16.
- One sub-module: `sata_prim_decode`, combinational dword+charisk -> {is_align, is_cont, is_data, is_unknown, onehot[15:0]}; FSM/registers in top.

## Test plan
- After reset, phy_ready=1, drive X_RDY,X_RDY,CONT,0x12345678(k0),0xDEADBEEF(k0) -> prim_vec=0x0080 for all 5 output cycles, data_valid=0, cont_active=1 from cycle 3.
- In CONT of HOLD, insert ALIGN then junk -> align_det=1, prim_vec=0 at ALIGN; junk cycle prim_vec=0x0200 again.
- SOF, data 0xA5A5A5A5, CONT -> SOF prim_vec=0x0020; data_valid=1 data_out=0xA5A5A5A5; CONT ignored, all strobes 0.
- Dword 0x0000007C charisk 0001 outside CONT -> unknown_prim=1; same dword with rx_err=0001 -> dword_err=1, err_cnt+1 (macro on), 0 (macro off).
- Drive 2^16+3 errored dwords, ERR_CNT_WIDTH=16 -> err_cnt stays 0xFFFF.
- Drop phy_ready mid-CONT, then rst_n low mid-stream -> outputs 0 next cycle / immediately; subsequent CONT ignored until new primitive.
